// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter. A WIDTH-bit word is loaded
//               with a valid/ready handshake and shifted out one bit at a time.
//               Each bit is held for CLKS_PER_BIT clocks. Framing strobes
//               (sout_valid, sout_last) allow a downstream receiver to rebuild
//               the word.
// Ports       : clk        - system clock, rising-edge active
//               reset      - asynchronous active-low reset
//               din        - parallel word to transmit
//               din_valid  - din holds a word to load
//               din_ready  - a word can be accepted this cycle (registered)
//               sout       - serial data bit
//               sout_valid - sout carries a frame bit
//               sout_last  - sout carries the final bit of the frame
//               busy       - frame in progress
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 1,
    parameter bit LSB_FIRST    = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int BIT_W = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = ($clog2(CLKS_PER_BIT) > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] PENULT_BIT = BIT_W'(WIDTH - 2);
    localparam logic [DIV_W-1:0] DIV_MAX    = DIV_W'(CLKS_PER_BIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_shreg;
    logic [BIT_W-1:0]  r_bit_cnt;
    logic [DIV_W-1:0]  r_div_cnt;

    // The shift register holds only the bits still waiting to be sent; the
    // bit currently on sout has already been moved into the sout register.
    // The next bit therefore always sits at the "outgoing" end of r_shreg.
    logic              w_first_bit;
    logic              w_next_bit;
    logic [WIDTH-1:0]  w_load_val;
    logic [WIDTH-1:0]  w_shift_val;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_first_bit = din[0];
            assign w_load_val  = din >> 1;
            assign w_next_bit  = r_shreg[0];
            assign w_shift_val = r_shreg >> 1;
        end else begin : g_msb_first
            assign w_first_bit = din[WIDTH-1];
            assign w_load_val  = din << 1;
            assign w_next_bit  = r_shreg[WIDTH-1];
            assign w_shift_val = r_shreg << 1;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_cnt  <= '0;
            r_div_cnt  <= '0;
            din_ready  <= 1'b0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (din_ready && din_valid) begin
                        r_state    <= ST_SHIFT;
                        r_shreg    <= w_load_val;
                        r_bit_cnt  <= '0;
                        r_div_cnt  <= '0;
                        din_ready  <= 1'b0;
                        sout       <= w_first_bit;
                        sout_valid <= 1'b1;
                        // WIDTH >= 2, so the first bit is never the last one
                        sout_last  <= 1'b0;
                        busy       <= 1'b1;
                    end else begin
                        // Also raises din_ready on the first edge after reset
                        din_ready  <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (r_div_cnt == DIV_MAX) begin
                        r_div_cnt <= '0;
                        if (r_bit_cnt == LAST_BIT) begin
                            r_state    <= ST_IDLE;
                            r_bit_cnt  <= '0;
                            r_shreg    <= '0;
                            din_ready  <= 1'b1;
                            sout       <= 1'b0;
                            sout_valid <= 1'b0;
                            sout_last  <= 1'b0;
                            busy       <= 1'b0;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            r_shreg   <= w_shift_val;
                            sout      <= w_next_bit;
                            sout_last <= (r_bit_cnt == PENULT_BIT);
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Self-checking bench for piso_serializer. Two instances:
//               A = defaults (WIDTH=4, CLKS_PER_BIT=1, MSB first)
//               B = WIDTH=8, CLKS_PER_BIT=3, LSB first
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       reset;

    logic [3:0] din_a;
    logic       valid_a;
    logic       ready_a, sout_a, sv_a, sl_a, busy_a;

    logic [7:0] din_b;
    logic       valid_b;
    logic       ready_b, sout_b, sv_b, sl_b, busy_b;

    always #5 clk = ~clk;

    piso_serializer dut_a (
        .clk        (clk),
        .reset      (reset),
        .din        (din_a),
        .din_valid  (valid_a),
        .din_ready  (ready_a),
        .sout       (sout_a),
        .sout_valid (sv_a),
        .sout_last  (sl_a),
        .busy       (busy_a)
    );

    piso_serializer #(
        .WIDTH        (8),
        .CLKS_PER_BIT (3),
        .LSB_FIRST    (1'b1)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .din        (din_b),
        .din_valid  (valid_b),
        .din_ready  (ready_b),
        .sout       (sout_b),
        .sout_valid (sv_b),
        .sout_last  (sl_b),
        .busy       (busy_b)
    );

    int total = 0;
    int bad   = 0;

    // Table record: word offered and the serial stream expected, written in
    // time order (leftmost bit of exp_seq's low WIDTH bits goes out first).
    typedef struct {
        int         which;
        logic [7:0] word;
        logic [7:0] exp_seq;
    } vec_t;

    vec_t tbl[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0b want %0b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {din_ready, sout, sout_valid, sout_last, busy}
    function automatic logic [4:0] outs(input int which);
        if (which == 0) return {ready_a, sout_a, sv_a, sl_a, busy_a};
        return {ready_b, sout_b, sv_b, sl_b, busy_b};
    endfunction

    task automatic drive(input int which, input logic [7:0] w, input logic v);
        if (which == 0) begin
            din_a   = w[3:0];
            valid_a = v;
        end else begin
            din_b   = w;
            valid_b = v;
        end
    endtask

    function automatic int wid(input int which);
        return (which == 0) ? 4 : 8;
    endfunction

    function automatic int cpb(input int which);
        return (which == 0) ? 1 : 3;
    endfunction

    // Reference: the k-th transmitted bit is word[k] for LSB-first, else
    // word[W-1-k]; the result is packed in time order.
    function automatic logic [7:0] model_seq(input int which, input logic [7:0] word);
        logic [7:0] seq;
        int         w;
        seq = '0;
        w   = wid(which);
        for (int k = 0; k < w; k++)
            seq[w-1-k] = (which == 1) ? word[k] : word[w-1-k];
        return seq;
    endfunction

    // Offers 'word', waits for acceptance, then checks every cycle of the
    // frame. At slot change_at the inputs switch to {later, keep_valid}.
    task automatic send_frame(input int which, input string tag, input logic [7:0] word,
                              input logic [7:0] exp_seq, input logic [7:0] later,
                              input int change_at, input logic keep_valid);
        int         w, c, n, idx;
        logic [4:0] o;
        logic       expb, expl;
        w = wid(which);
        c = cpb(which);
        n = 0;
        drive(which, word, 1'b1);
        o = outs(which);
        while (o[4] !== 1'b1 && n < 50) begin
            tick();
            n++;
            o = outs(which);
        end
        if (n >= 50) begin
            check({tag, " ready_timeout"}, 32'd0, 32'd1);
            drive(which, 8'h00, 1'b0);
            return;
        end
        tick(); // capture edge N
        for (int i = 0; i < w * c; i++) begin
            if (i == change_at) drive(which, later, keep_valid);
            idx  = i / c;
            expb = exp_seq[w-1-idx];
            expl = (idx == w - 1);
            check($sformatf("%s slot%0d", tag, i), 32'(outs(which)),
                  32'({1'b0, expb, 1'b1, expl, 1'b1}));
            tick();
        end
        check({tag, " end_idle"}, 32'(outs(which)), 32'(5'b10000));
    endtask

    initial begin
        tbl[0] = '{which: 0, word: 8'h0B, exp_seq: 8'h0B};
        tbl[1] = '{which: 0, word: 8'h08, exp_seq: 8'h08};
        tbl[2] = '{which: 1, word: 8'hA5, exp_seq: 8'hA5};
        tbl[3] = '{which: 1, word: 8'h01, exp_seq: 8'h80};
        tbl[4] = '{which: 1, word: 8'hF0, exp_seq: 8'h0F};

        // Reset held with a word offered: nothing captured, all outputs 0
        reset   = 1'b0;
        din_a   = 4'b1010;
        valid_a = 1'b1;
        din_b   = 8'h00;
        valid_b = 1'b0;
        #1;
        check("reset_no_edge", 32'(outs(0)), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_hold%0d", i), 32'(outs(0)), 32'd0);
        end
        check("reset_b", 32'(outs(1)), 32'd0);
        reset = 1'b1;
        tick();
        check("ready_after_release", 32'(outs(0)), 32'(5'b10000));
        send_frame(0, "post_reset", 8'h0A, 8'h0A, 8'h00, 0, 1'b0);

        // Table: single frames, valid pulsed for one cycle
        for (int t = 0; t < 5; t++)
            send_frame(tbl[t].which, $sformatf("tbl%0d", t), tbl[t].word,
                       tbl[t].exp_seq, ~tbl[t].word, 0, 1'b0);

        // Back-to-back with valid held; second word presented at first accept
        send_frame(0, "b2b_first", 8'h06, 8'h06, 8'h09, 0, 1'b1);
        send_frame(0, "b2b_second", 8'h09, 8'h09, 8'h00, 0, 1'b0);

        // Data change during shift must not affect the frame in flight
        send_frame(0, "din_change", 8'h0C, 8'h0C, 8'h03, 2, 1'b0);

        // Asynchronous reset during bit 2
        drive(0, 8'h06, 1'b1);
        tick(); // capture
        drive(0, 8'h06, 1'b0);
        tick();
        tick();
        check("abort_pre", 32'(outs(0)), 32'(5'b01101));
        #3;
        reset = 1'b0;
        #1;
        check("abort_immediate", 32'(outs(0)), 32'd0);
        tick();
        tick();
        check("abort_held", 32'(outs(0)), 32'd0);
        reset = 1'b1;
        tick();
        check("abort_ready", 32'(outs(0)), 32'(5'b10000));
        send_frame(0, "after_abort", 8'h05, 8'h05, 8'h00, 0, 1'b0);

        // Randomized words against the reference model
        for (int r = 0; r < 12; r++) begin
            int         which;
            logic [7:0] word;
            which = r % 2;
            word  = 8'($urandom_range(0, 255));
            if (which == 0) word[7:4] = 4'h0;
            send_frame(which, $sformatf("rand%0d", r), word, model_seq(which, word),
                       8'($urandom_range(0, 255)),
                       int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            drive(which, 8'h00, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
